// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus iterative 16-cycle mul/div/rem.
// Registers result and memory/writeback controls for the memory stage.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_alu_op,
  input  logic [15:0] id_op_a,
  input  logic [15:0] id_op_b,
  input  logic [15:0] id_store_data,
  input  logic [2:0]  id_op_dest,
  input  logic        id_mem_write_en,
  input  logic        id_wb_mux,
  input  logic        id_wb_en,
  output logic [15:0] ex_alu_res,
  output logic [15:0] ex_store_data,
  output logic [2:0]  ex_op_dest,
  output logic        ex_mem_write_en,
  output logic        ex_wb_mux,
  output logic        ex_wb_en,
  output logic        ex_stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;
  localparam logic [3:0] OP_REM = 4'd12;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] sd_q, sd_d;
  logic [2:0]  dest_q, dest_d;
  logic        we_q, we_d;
  logic        mux_q, mux_d;
  logic        wb_q, wb_d;

  logic [15:0] res_q, res_d;
  logic [15:0] osd_q, osd_d;
  logic [2:0]  odest_q, odest_d;
  logic        owe_q, owe_d;
  logic        omux_q, omux_d;
  logic        owb_q, owb_d;

  logic        is_multi;
  logic [15:0] alu_res;
  logic [15:0] mul_acc;
  logic [16:0] div_sh;
  logic [16:0] div_diff;

  assign is_multi = (id_alu_op == OP_MUL) ||
                    (id_alu_op == OP_DIV) ||
                    (id_alu_op == OP_REM);

  assign ex_stall = !rst &&
    ((state_q == IDLE && id_valid && is_multi) ||
     (state_q == BUSY));

  always_comb begin
    alu_res = 16'h0000;
    case (id_alu_op)
      4'd0:  alu_res = id_op_a + id_op_b;
      4'd1:  alu_res = id_op_a - id_op_b;
      4'd2:  alu_res = id_op_a & id_op_b;
      4'd3:  alu_res = id_op_a | id_op_b;
      4'd4:  alu_res = id_op_a ^ id_op_b;
      4'd5:  alu_res = ~(id_op_a | id_op_b);
      4'd6:  alu_res = id_op_a << id_op_b[3:0];
      4'd7:  alu_res = id_op_a >> id_op_b[3:0];
      4'd8:  alu_res = $signed(id_op_a) >>> id_op_b[3:0];
      4'd9:  alu_res = {15'd0,
               $signed(id_op_a) < $signed(id_op_b)};
      4'd13: alu_res = id_op_b;
      default: alu_res = 16'h0000;
    endcase
  end

  // a_q doubles as multiplicand / dividend-then-quotient,
  // b_q as multiplier / divisor, acc_q as product / remainder.
  assign mul_acc  = acc_q + (b_q[0] ? a_q : 16'h0000);
  assign div_sh   = {acc_q, a_q[15]};
  assign div_diff = div_sh - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    op_d    = op_q;
    sd_d    = sd_q;
    dest_d  = dest_q;
    we_d    = we_q;
    mux_d   = mux_q;
    wb_d    = wb_q;
    res_d   = 16'h0000;
    osd_d   = 16'h0000;
    odest_d = 3'd0;
    owe_d   = 1'b0;
    omux_d  = 1'b0;
    owb_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (id_valid && is_multi) begin
          a_d     = id_op_a;
          b_d     = id_op_b;
          acc_d   = 16'h0000;
          op_d    = id_alu_op;
          sd_d    = id_store_data;
          dest_d  = id_op_dest;
          we_d    = id_mem_write_en;
          mux_d   = id_wb_mux;
          wb_d    = id_wb_en;
          cnt_d   = 5'd16;
          state_d = BUSY;
        end else if (id_valid) begin
          res_d   = alu_res;
          osd_d   = id_store_data;
          odest_d = id_op_dest;
          owe_d   = id_mem_write_en;
          omux_d  = id_wb_mux;
          owb_d   = id_wb_en;
        end
      end
      BUSY: begin
        if (op_q == OP_MUL) begin
          acc_d = mul_acc;
          a_d   = {a_q[14:0], 1'b0};
          b_d   = {1'b0, b_q[15:1]};
        end else if (!div_diff[16]) begin
          acc_d = div_diff[15:0];
          a_d   = {a_q[14:0], 1'b1};
        end else begin
          acc_d = div_sh[15:0];
          a_d   = {a_q[14:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = DONE;
      end
      DONE: begin
        res_d   = (op_q == OP_DIV) ? a_q : acc_q;
        osd_d   = sd_q;
        odest_d = dest_q;
        owe_d   = we_q;
        omux_d  = mux_q;
        owb_d   = wb_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      acc_q   <= 16'h0000;
      op_q    <= 4'd0;
      sd_q    <= 16'h0000;
      dest_q  <= 3'd0;
      we_q    <= 1'b0;
      mux_q   <= 1'b0;
      wb_q    <= 1'b0;
      res_q   <= 16'h0000;
      osd_q   <= 16'h0000;
      odest_q <= 3'd0;
      owe_q   <= 1'b0;
      omux_q  <= 1'b0;
      owb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      sd_q    <= sd_d;
      dest_q  <= dest_d;
      we_q    <= we_d;
      mux_q   <= mux_d;
      wb_q    <= wb_d;
      res_q   <= res_d;
      osd_q   <= osd_d;
      odest_q <= odest_d;
      owe_q   <= owe_d;
      omux_q  <= omux_d;
      owb_q   <= owb_d;
    end
  end

  assign ex_alu_res      = res_q;
  assign ex_store_data   = osd_q;
  assign ex_op_dest      = odest_q;
  assign ex_mem_write_en = owe_q;
  assign ex_wb_mux       = omux_q;
  assign ex_wb_en        = owb_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU sweep, mul/div/rem latency,
// divide by zero, reset during BUSY and back-to-back issue.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_alu_op;
  logic [15:0] id_op_a;
  logic [15:0] id_op_b;
  logic [15:0] id_store_data;
  logic [2:0]  id_op_dest;
  logic        id_mem_write_en;
  logic        id_wb_mux;
  logic        id_wb_en;
  logic [15:0] ex_alu_res;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_op_dest;
  logic        ex_mem_write_en;
  logic        ex_wb_mux;
  logic        ex_wb_en;
  logic        ex_stall;

  int checks = 0;
  int failures = 0;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_op_a(id_op_a), .id_op_b(id_op_b),
    .id_store_data(id_store_data), .id_op_dest(id_op_dest),
    .id_mem_write_en(id_mem_write_en), .id_wb_mux(id_wb_mux),
    .id_wb_en(id_wb_en),
    .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data),
    .ex_op_dest(ex_op_dest), .ex_mem_write_en(ex_mem_write_en),
    .ex_wb_mux(ex_wb_mux), .ex_wb_en(ex_wb_en),
    .ex_stall(ex_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] sd,
                       input logic [2:0] dest, input logic we,
                       input logic mux, input logic wb);
    id_valid = 1'b1;
    id_alu_op = op;
    id_op_a = a;
    id_op_b = b;
    id_store_data = sd;
    id_op_dest = dest;
    id_mem_write_en = we;
    id_wb_mux = mux;
    id_wb_en = wb;
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0;
    #1;
  endtask

  task automatic alu1(input string tag, input logic [3:0] op,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp);
    issue(op, a, b, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1);
    chk({tag, "_stall"}, {15'd0, ex_stall}, 16'd0);
    tick();
    chk(tag, ex_alu_res, exp);
  endtask

  task automatic run_multi(input string tag, input logic [3:0] op,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] dest,
                           input logic [15:0] exp);
    int st = 0;
    int bub = 0;
    issue(op, a, b, 16'h0000, dest, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      if (ex_stall) st++;
      tick();
      if (!ex_wb_en && ex_alu_res == 16'h0 && ex_op_dest == 3'd0) bub++;
    end
    chk({tag, "_stall_cycles"}, 16'(st), 16'd17);
    chk({tag, "_bubbles"}, 16'(bub), 16'd17);
    chk({tag, "_done_stall"}, {15'd0, ex_stall}, 16'd0);
    tick();
    chk(tag, ex_alu_res, exp);
    chk({tag, "_dest"}, {13'd0, ex_op_dest}, {13'd0, dest});
    chk({tag, "_wb_en"}, {15'd0, ex_wb_en}, 16'd1);
  endtask

  initial begin
    int stray;
    rst = 1'b1;
    id_valid = 1'b0;
    id_alu_op = 4'd0;
    id_op_a = 16'h0;
    id_op_b = 16'h0;
    id_store_data = 16'h0;
    id_op_dest = 3'd0;
    id_mem_write_en = 1'b0;
    id_wb_mux = 1'b0;
    id_wb_en = 1'b0;
    #12;
    chk("reset_res", ex_alu_res, 16'h0);
    chk("reset_wb_en", {15'd0, ex_wb_en}, 16'd0);
    chk("reset_stall", {15'd0, ex_stall}, 16'd0);
    rst = 1'b0;
    tick();

    alu1("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 16'h0000);
    alu1("sub_wrap", 4'd1, 16'h0000, 16'h0001, 16'hFFFF);
    alu1("sra", 4'd8, 16'h8000, 16'h000F, 16'hFFFF);
    alu1("slt", 4'd9, 16'hFFFF, 16'h0001, 16'h0001);
    alu1("passb", 4'd13, 16'h5555, 16'h1234, 16'h1234);
    alu1("nor", 4'd5, 16'h00F0, 16'h0F00, 16'hF00F);
    alu1("srl", 4'd7, 16'h8000, 16'h0004, 16'h0800);
    alu1("op15", 4'd15, 16'h1111, 16'h2222, 16'h0000);

    issue(4'd0, 16'h0010, 16'h0020, 16'hABCD, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("store_addr", ex_alu_res, 16'h0030);
    chk("store_we", {15'd0, ex_mem_write_en}, 16'd1);
    chk("store_data", ex_store_data, 16'hABCD);
    idle();
    tick();
    chk("bubble_we", {15'd0, ex_mem_write_en}, 16'd0);

    run_multi("mul", 4'd10, 16'd300, 16'd300, 3'd5, 16'h5F90);
    run_multi("div", 4'd11, 16'd1000, 16'd7, 3'd2, 16'd142);
    run_multi("rem", 4'd12, 16'd1000, 16'd7, 3'd3, 16'd6);
    run_multi("div0", 4'd11, 16'h1234, 16'h0000, 3'd4, 16'hFFFF);
    run_multi("rem0", 4'd12, 16'h1234, 16'h0000, 3'd6, 16'h1234);

    issue(4'd11, 16'd1000, 16'd7, 16'h0, 3'd3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("busy_stall", {15'd0, ex_stall}, 16'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_stall", {15'd0, ex_stall}, 16'd0);
    chk("rst_res", ex_alu_res, 16'h0);
    chk("rst_dest", {13'd0, ex_op_dest}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    chk("post_rst_stall", {15'd0, ex_stall}, 16'd0);
    alu1("post_rst_add", 4'd0, 16'd3, 16'd4, 16'd7);
    idle();
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ex_wb_en || ex_stall) stray++;
    end
    chk("no_stale_div", 16'(stray), 16'd0);

    alu1("b2b_add1", 4'd0, 16'd1, 16'd2, 16'd3);
    run_multi("b2b_mul", 4'd10, 16'd300, 16'd300, 3'd5, 16'h5F90);
    alu1("b2b_add2", 4'd0, 16'd5, 16'd6, 16'd11);
    idle();
    tick();
    chk("b2b_no_dup", {15'd0, ex_wb_en}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit pipelined core. Sits between decode and the memory stage. Performs single-cycle ALU operations and iterative 16-cycle multiply/divide/remainder, and registers the result plus the load/store/writeback controls that the memory stage consumes. While an iterative operation is in flight, it stalls the front end and emits bubbles.

## Interface
Parameters:
- none (datapath fixed at 16 bits, register index 3 bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  decode presents a valid instruction this cycle
- id_alu_op  in  4  operation select (encoding below)
- id_op_a  in  16  operand A (forwarding already resolved upstream)
- id_op_b  in  16  operand B / shift amount / immediate
- id_store_data  in  16  data for store instructions
- id_op_dest  in  3  destination register index
- id_mem_write_en  in  1  instruction is a store
- id_wb_mux  in  1  writeback select (1 = memory data, 0 = ALU result)
- id_wb_en  in  1  instruction writes a register
- ex_alu_res  out  16  registered result; also the memory address
- ex_store_data  out  16  registered store data
- ex_op_dest  out  3  registered destination index
- ex_mem_write_en  out  1  registered store enable
- ex_wb_mux  out  1  registered writeback select
- ex_wb_en  out  1  registered writeback enable
- ex_stall  out  1  combinational; decode/fetch must hold their outputs while high

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLL, 7 SRL, 8 SRA; shift amount is op_b[3:0]
  - 9 SLT: signed compare, result 16'h0001 or 16'h0000
  - 10 MUL: low 16 bits of the unsigned product
  - 11 DIV: unsigned quotient
  - 12 REM: unsigned remainder
  - 13 PASSB: result = op_b
  - 14, 15: result 0
- ADD/SUB wrap modulo 2^16. There are no flags.
- Bubble: output register loads alu_res = 0, store_data = 0, dest = 0, and all control bits = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - id_valid = 0: load a bubble.
  - Valid single-cycle op: load the result, id_store_data, and the control bits.
  - Valid op 10/11/12:
    - ex_stall = 1.
    - Latch the operands, op, dest, wb_mux, wb_en, mem_write_en, and store_data.
    - Set cnt = 16, go to BUSY, load a bubble.
- BUSY:
  - ex_stall = 1. Each edge runs one iteration and decrements cnt; a bubble is loaded.
  - MUL uses shift-add on a 16-bit accumulator.
  - DIV/REM use restoring division on a 16-bit remainder register.
  - The edge with cnt = 1 transitions to DONE.
- DONE:
  - ex_stall = 0.
  - The decode inputs are ignored; they still show the held multicycle instruction and advance on this edge.
  - Load the final result with the latched controls, then return to IDLE.
- Divide by zero: quotient 16'hFFFF, remainder = dividend. No exception is raised.
- Asynchronous reset, including mid-BUSY: state IDLE, cnt 0, latched operands 0, every registered output 0. ex_stall is forced 0 while rst is high.

## Timing
- Single-cycle op presented in cycle c appears on the outputs after the edge ending cycle c (latency 1). Back-to-back single-cycle ops sustain 1 per cycle.
- Multicycle op presented in cycle c0:
  - ex_stall is high in cycles c0..c16 (17 cycles).
  - c17 is DONE.
  - The result appears after the edge ending c17 (latency 18).
  - Exactly 17 bubbles precede the result.
- The instruction following a multicycle op is first sampled in the cycle after DONE.
- ex_stall is a function of state, id_valid and id_alu_op only. It has no combinational path from the operands.

## Test plan
- Reset mid-stream: assert rst during BUSY of a DIV → all outputs 0 and ex_stall 0 immediately; after release, ADD 3+4 → ex_alu_res = 7 one edge later.
- Single-cycle sweep:
  - ADD 16'hFFFF+1 → 0.
  - SUB 0-1 → 16'hFFFF.
  - SRA 16'h8000 by 15 → 16'hFFFF.
  - SLT -1 < 1 → 1.
  - PASSB 16'h1234 → 16'h1234.
  - A store op → ex_mem_write_en = 1 and ex_store_data passed through.
- MUL 300×300 (dest 5, wb_en 1):
  - ex_stall high for exactly 17 cycles and 17 bubbles.
  - Then ex_alu_res = 16'h5F90 (90000 mod 65536 = 24464), ex_op_dest = 5, ex_wb_en = 1.
- DIV 1000/7 → 142; REM 1000/7 → 6. Each has latency 18.
- DIV 16'h1234/0 → 16'hFFFF; REM 16'h1234/0 → 16'h1234.
- Back-to-back ADD, MUL, ADD with id_valid held high and decode obeying ex_stall → results in order, with 17 bubbles only after the MUL and no duplicate MUL result.
